// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency 128-bit line memory responder with protocol-error detection.
module pmem_responder #(
  parameter int LATENCY   = 4,
  parameter int LOG_LINES = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         proto_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic op_write;
  logic [LOG_LINES-1:0] idx;
  logic [127:0] wdata;
  logic [127:0] mem [2**LOG_LINES] = '{default: '0};
  logic req, accept, abort, fire;
  logic unused_addr;
  assign unused_addr = ^{pmem_address[15:LOG_LINES+4], pmem_address[3:0]};
  assign req    = pmem_read | pmem_write;
  assign accept = state == IDLE && req;
  assign abort  = state == BUSY && !req;
  assign fire   = state == BUSY && req && cnt == '0;
  assign busy   = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (req ? BUSY : IDLE) :
              state == BUSY ? (!req ? IDLE : (cnt == '0 ? RESP : BUSY)) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      pmem_resp <= fire;
      if (accept) cnt <= 4'(LATENCY - 1);
      else if (state == BUSY && req && cnt != '0) cnt <= cnt - 4'd1;
      if (fire && !op_write) pmem_rdata <= mem[idx];
      if ((accept && pmem_read && pmem_write) || abort) proto_err <= 1'b1;
    end
  end
  // Request fields are captured once at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      op_write <= pmem_write;
      idx      <= pmem_address[LOG_LINES+3:4];
      wdata    <= pmem_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && fire && op_write) mem[idx] <= wdata;
  end
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: table-driven, hand-sequenced and randomized checks of pmem_responder.
module tb_pmem_responder;
  logic clk = 0, reset = 1, rd = 0, wr = 0, sel = 0;
  logic [15:0] addr = '0;
  logic [127:0] wdata = '0;
  logic resp0, busy0, err0, resp1, busy1, err1;
  logic [127:0] rdata0, rdata1;
  logic rd0, wr0, rd1, wr1, resp_s, err_s;
  logic [127:0] rdata_s;
  int tests = 0, fails = 0;
  logic [127:0] model [2][32];
  assign rd0 = rd & ~sel;
  assign wr0 = wr & ~sel;
  assign rd1 = rd & sel;
  assign wr1 = wr & sel;
  assign resp_s  = sel ? resp1 : resp0;
  assign rdata_s = sel ? rdata1 : rdata0;
  assign err_s   = sel ? err1 : err0;
  always #5 clk = ~clk;

  pmem_responder #(.LATENCY(4), .LOG_LINES(5)) dut0 (
    .clk(clk), .reset(reset), .pmem_read(rd0), .pmem_write(wr0), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_resp(resp0), .pmem_rdata(rdata0), .busy(busy0), .proto_err(err0));
  pmem_responder #(.LATENCY(1), .LOG_LINES(5)) dut1 (
    .clk(clk), .reset(reset), .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_resp(resp1), .pmem_rdata(rdata1), .busy(busy1), .proto_err(err1));

  typedef struct {
    logic r, w;
    logic [15:0] a;
    logic [127:0] d, exp;
    logic exp_err;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1; rd = 0; wr = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
  endtask

  // Issue one request, hold it until the response, and check timing/data against the model.
  task automatic run_op(input logic r, input logic w, input logic [15:0] a, input logic [127:0] d,
                        input string name);
    int lat = sel ? 1 : 4;
    int hit = -1, n = 0;
    logic [127:0] exp = model[sel][a[8:4]];
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (resp_s) begin
        n++;
        if (hit < 0) hit = k;
        if (n == 1 && r && !w) check({name, " rdata"}, rdata_s, exp);
        rd = 0; wr = 0;
      end
    end
    rd = 0; wr = 0;
    check({name, " resp cycle"}, 128'(hit), 128'(lat + 1));
    check({name, " resp count"}, 128'(n), 128'd1);
    if (w) model[sel][a[8:4]] = d;
  endtask

  initial begin
    vec_t tbl [7];
    bit seen;
    logic [127:0] v;
    logic [15:0] ra;
    logic [15:0] bb [4];
    int j;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) model[s][i] = '0;
    tbl[0] = '{1'b0, 1'b1, 16'h0010, 128'h0123456789ABCDEF0123456789ABCDEF, '0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, '0, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h0200, {8{16'hAAAA}}, '0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, '0, {8{16'hAAAA}}, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h0020, '0, '0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h0030, {8{16'h5555}}, '0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 16'h0030, '0, {8{16'h5555}}, 1'b1};
    do_reset();
    check("reset resp", 128'(resp0), 0);
    check("reset rdata", rdata0, 0);
    check("reset busy", 128'(busy0), 0);
    check("reset err", 128'(err0), 0);

    foreach (tbl[i]) begin
      if (tbl[i].r && !tbl[i].w) check($sformatf("vec%0d model", i), model[0][tbl[i].a[8:4]], tbl[i].exp);
      run_op(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, $sformatf("vec%0d", i));
      check($sformatf("vec%0d err", i), 128'(err0), 128'(tbl[i].exp_err));
    end

    do_reset();
    check("reset clears err", 128'(err0), 0);
    run_op(1'b1, 1'b0, 16'h0010, '0, "mem kept over reset");

    rd = 1; addr = 16'h0010;
    @(posedge clk); @(negedge clk); @(negedge clk);
    rd = 0; seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= resp0;
      if (k == 0) check("abort busy", 128'(busy0), 0);
    end
    check("abort err", 128'(err0), 1);
    check("abort no resp", 128'(seen), 0);

    wr = 1; addr = 16'h0010; wdata = {8{16'hBEEF}};
    @(posedge clk); @(negedge clk); @(negedge clk);
    reset = 1; wr = 0;
    @(negedge clk);
    reset = 0;
    check("rst busy", 128'(busy0), 0);
    check("rst rdata", rdata0, 0);
    check("rst err", 128'(err0), 0);
    seen = resp0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= resp0;
    end
    check("rst no resp", 128'(seen), 0);
    run_op(1'b1, 1'b0, 16'h0010, '0, "rst no write");

    for (int i = 0; i < 40; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      ra = 16'($urandom);
      if ($urandom_range(1)) run_op(1'b0, 1'b1, ra, v, $sformatf("rnd%0d wr", i));
      else run_op(1'b1, 1'b0, ra, '0, $sformatf("rnd%0d rd", i));
    end
    check("rnd err", 128'(err0), 0);

    sel = 1;
    for (int i = 0; i < 4; i++) begin
      bb[i] = 16'(i * 16 + 16);
      run_op(1'b0, 1'b1, bb[i], {$urandom, $urandom, $urandom, $urandom}, $sformatf("l1 wr%0d", i));
    end
    j = 0; rd = 1; addr = bb[0];
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("b2b resp k%0d", k), 128'(resp1), 128'(k % 3 == 2));
      if (resp1) begin
        check($sformatf("b2b rdata %0d", j), rdata1, model[1][bb[j][8:4]]);
        j++;
        addr = bb[j];
      end
      if (k == 9) rd = 0;
    end
    check("b2b count", 128'(j), 3);
    check("b2b err", 128'(err_s), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
